mult_exp_sequencer: RTL and testbench

- FSM that sequences the multiplier's exponent phase: the exponent adder register, the underflow comparator register and the bias subtraction.
- Drives the load_a / load_b strobes of the exponent-add stage and reads back its registered sum (Exp_Add) and underflow flag.
- Removes the bias, detects overflow and presents the final biased exponent with a valid/ack handshake to the multiplier top-level control.

---
 rtl/mult_exp_sequencer.sv | 116 +++++++++++
 tb/tb_mult_exp_sequencer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/mult_exp_sequencer.sv
// Exponent-phase sequencer for the floating-point multiplier.
// Strobes the exponent-add stage, then takes its registered sum and underflow
// flag, removes the bias, and saturates on overflow. The result is offered to
// the top-level control with a ready/ack handshake.
module mult_exp_sequencer #(
  parameter int W_Exp = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             ack_i,
  input  logic [W_Exp:0]   Exp_Add_i,
  input  logic             underflow_i,
  output logic             load_a_o,
  output logic             load_b_o,
  output logic             busy_o,
  output logic             ready_o,
  output logic [W_Exp-1:0] Exp_Result_o,
  output logic             overflow_o,
  output logic             underflow_o
);

  // Bias 2^(W_Exp-1)-1 and the saturation threshold 2^W_Exp-1, both held at
  // W_Exp+2 bits so the subtraction cannot lose its borrow.
  localparam logic [W_Exp+1:0] BIAS_VAL = {3'b000, {(W_Exp-1){1'b1}}};
  localparam logic [W_Exp+1:0] OVF_LIM  = {2'b00, {W_Exp{1'b1}}};

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    BIAS   = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [W_Exp-1:0]   res_q, res_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;

  // Bias removal with priority underflow > overflow > plain result.
  // Packed return: {exponent, overflow, underflow}.
  function automatic logic [W_Exp+1:0] unbias_sat(input logic [W_Exp:0] sum,
                                                  input logic           unf);
    logic [W_Exp+1:0] diff;
    diff = {1'b0, sum} - BIAS_VAL;
    if (unf)
      unbias_sat = {{W_Exp{1'b0}}, 1'b0, 1'b1};
    else if (diff >= OVF_LIM)
      unbias_sat = {{W_Exp{1'b1}}, 1'b1, 1'b0};
    else
      unbias_sat = {diff[W_Exp-1:0], 1'b0, 1'b0};
  endfunction

  // State register; reset returns to IDLE regardless of other inputs.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic and Moore outputs decoded from the registered state.
  always_comb begin
    state_d  = state_q;
    load_a_o = 1'b0;
    load_b_o = 1'b0;
    busy_o   = 1'b1;
    ready_o  = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy_o = 1'b0;
        if (start_i) state_d = LOAD_A;
      end
      LOAD_A: begin
        load_a_o = 1'b1;
        state_d  = LOAD_B;
      end
      LOAD_B: begin
        load_b_o = 1'b1;
        state_d  = BIAS;
      end
      BIAS: begin
        state_d = DONE;
      end
      DONE: begin
        ready_o = 1'b1;
        if (ack_i) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Result candidate, only captured on the edge leaving BIAS.
  always_comb begin
    {res_d, ovf_d, unf_d} = unbias_sat(Exp_Add_i, underflow_i);
  end

  // Result registers hold through DONE and IDLE; cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      res_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (state_q == BIAS) begin
      res_q <= res_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign Exp_Result_o = res_q;
  assign overflow_o   = ovf_q;
  assign underflow_o  = unf_q;

endmodule

// File: tb/tb_mult_exp_sequencer.sv
// Directed bench for mult_exp_sequencer (W_Exp = 8, bias 127).
module tb_mult_exp_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_i;
  logic       ack_i;
  logic [8:0] Exp_Add_i;
  logic       underflow_i;
  logic       load_a_o;
  logic       load_b_o;
  logic       busy_o;
  logic       ready_o;
  logic [7:0] Exp_Result_o;
  logic       overflow_o;
  logic       underflow_o;

  int n_cmp = 0;
  int n_bad = 0;

  mult_exp_sequencer #(.W_Exp(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .ack_i        (ack_i),
    .Exp_Add_i    (Exp_Add_i),
    .underflow_i  (underflow_i),
    .load_a_o     (load_a_o),
    .load_b_o     (load_b_o),
    .busy_o       (busy_o),
    .ready_o      (ready_o),
    .Exp_Result_o (Exp_Result_o),
    .overflow_o   (overflow_o),
    .underflow_o  (underflow_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ctl(input string tag, input int la, input int lb,
                         input int bz, input int rd);
    chk({tag, ".load_a"}, int'(load_a_o), la);
    chk({tag, ".load_b"}, int'(load_b_o), lb);
    chk({tag, ".busy"},   int'(busy_o),   bz);
    chk({tag, ".ready"},  int'(ready_o),  rd);
  endtask

  task automatic chk_res(input string tag, input int res, input int ovf,
                         input int unf);
    chk({tag, ".exp"}, int'(Exp_Result_o), res);
    chk({tag, ".ovf"}, int'(overflow_o),   ovf);
    chk({tag, ".unf"}, int'(underflow_o),  unf);
  endtask

  // Start a transaction from IDLE and walk it to the first DONE cycle.
  task automatic run_to_done(input string tag, input int sum, input logic unf);
    Exp_Add_i   = 9'(sum);
    underflow_i = unf;
    start_i     = 1'b1;
    step();
    chk_ctl({tag, ".A"}, 1, 0, 1, 0);
    start_i = 1'b0;
    step();
    chk_ctl({tag, ".B"}, 0, 1, 1, 0);
    step();
    chk_ctl({tag, ".BIAS"}, 0, 0, 1, 0);
    step();
    chk_ctl({tag, ".DONE"}, 0, 0, 1, 1);
  endtask

  task automatic do_ack(input string tag);
    ack_i = 1'b1;
    step();
    ack_i = 1'b0;
    chk_ctl({tag, ".IDLE"}, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b0; start_i = 1'b1; ack_i = 1'b0;
    Exp_Add_i = 9'd200; underflow_i = 1'b0;
    step();
    step();
    chk_ctl("rst", 0, 0, 0, 0);
    chk_res("rst", 0, 0, 0);

    // Release reset with start already high: strobes in cycles 1 and 2.
    rst = 1'b1;
    run_to_done("first", 200, 1'b0);
    chk_res("first", 73, 0, 0);
    do_ack("first");
    chk_res("first.held", 73, 0, 0);

    run_to_done("norm", 257, 1'b0);
    chk_res("norm", 130, 0, 0);
    do_ack("norm");

    run_to_done("unf", 30, 1'b1);
    chk_res("unf", 0, 0, 1);
    do_ack("unf");

    run_to_done("zero", 127, 1'b0);
    chk_res("zero", 0, 0, 0);
    do_ack("zero");

    run_to_done("b381", 381, 1'b0);
    chk_res("b381", 254, 0, 0);
    do_ack("b381");

    run_to_done("b382", 382, 1'b0);
    chk_res("b382", 255, 1, 0);
    do_ack("b382");

    // Hold DONE without ack; input changes must not disturb the result.
    run_to_done("b508", 508, 1'b0);
    Exp_Add_i = 9'd257; underflow_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("hold.ready", int'(ready_o), 1);
      chk("hold.exp",   int'(Exp_Result_o), 255);
      chk("hold.ovf",   int'(overflow_o), 1);
      chk("hold.unf",   int'(underflow_o), 0);
    end

    // ack together with start: start ignored in DONE.
    start_i = 1'b1;
    ack_i   = 1'b1;
    step();
    ack_i = 1'b0;
    chk_ctl("ackstart", 0, 0, 0, 0);
    // start still high in IDLE now launches a new transaction.
    step();
    chk_ctl("restart", 1, 0, 1, 0);
    start_i = 1'b0;
    step(); step(); step();
    chk_ctl("restart.DONE", 0, 0, 1, 1);
    chk_res("restart", 0, 0, 1);
    do_ack("restart");

    // Load a known nonzero result, then reset mid-transaction in BIAS.
    run_to_done("pre", 508, 1'b0);
    do_ack("pre");
    Exp_Add_i = 9'd300; underflow_i = 1'b0; start_i = 1'b1;
    step();
    start_i = 1'b0;
    step();
    step();
    chk_ctl("mid.BIAS", 0, 0, 1, 0);
    rst = 1'b0;
    start_i = 1'b1;
    step();
    chk_ctl("midrst", 0, 0, 0, 0);
    chk_res("midrst", 0, 0, 0);
    rst = 1'b1;
    start_i = 1'b0;
    step();
    chk_ctl("postrst", 0, 0, 0, 0);
    run_to_done("after", 300, 1'b0);
    chk_res("after", 173, 0, 0);
    do_ack("after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
